// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: forwards words from four input FIFOs to four output FIFOs,
// routed by the word's top two bits. Define SCHED_STRICT_PRIO_EN for fixed priority.
module fifo_rr_scheduler #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    RESET_L,
    input  logic [3:0]              in_empty,
    input  logic [4*DATA_WIDTH-1:0] in_data,
    input  logic [3:0]              in_valid,
    output logic [3:0]              in_rd,
    input  logic [3:0]              out_almost_full,
    input  logic [3:0]              out_full,
    output logic [3:0]              out_wr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    active,
    output logic                    err,
    output logic [CNT_WIDTH-1:0]    fwd_count
);

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned IDX_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_PUSH
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       sel_q;
    logic [IDX_W-1:0]       dest_q;
    logic [NUM_PORTS-1:0]   in_rd_q;
    logic [NUM_PORTS-1:0]   out_wr_q;
    logic [DATA_WIDTH-1:0]  hold_q;
    logic                   active_q;
    logic                   err_q;
    logic [CNT_WIDTH-1:0]   fwd_count_q;

    logic [IDX_W-1:0]       search_base;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       grant_idx_d;
    logic                   grant_vld_d;
    logic [DATA_WIDTH-1:0]  in_word [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  sel_word;
    logic [IDX_W-1:0]       sel_dest;

`ifdef SCHED_STRICT_PRIO_EN
    assign search_base = '0;
`else
    logic [IDX_W-1:0]       ptr_q;
    assign search_base = ptr_q;
`endif

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign in_word[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sel_word = in_word[sel_q];
    assign sel_dest = sel_word[DATA_WIDTH-1 -: IDX_W];

    // First non-empty input at or after the search base, wrapping mod 4.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = search_base + IDX_W'(k);
            if (!grant_vld_d && !in_empty[cand]) begin
                grant_vld_d = 1'b1;
                grant_idx_d = cand;
            end
        end
    end

    // Transfer FSM; strobes default low so every pulse lasts exactly one cycle.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            dest_q      <= '0;
            in_rd_q     <= '0;
            out_wr_q    <= '0;
            hold_q      <= '0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            fwd_count_q <= '0;
`ifndef SCHED_STRICT_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            in_rd_q  <= '0;
            out_wr_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_d && (out_almost_full == '0)) begin
                        sel_q    <= grant_idx_d;
                        in_rd_q  <= 4'b0001 << grant_idx_d;
                        active_q <= 1'b1;
                        state_q  <= ST_POP;
                        // Popping an empty input is unreachable; kept as a self-check.
                        if (in_empty[grant_idx_d]) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_POP: begin
`ifndef SCHED_STRICT_PRIO_EN
                    ptr_q   <= sel_q + IDX_W'(1);
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (in_valid[sel_q]) begin
                        hold_q  <= sel_word;
                        dest_q  <= sel_dest;
                        state_q <= ST_PUSH;
                        if (!out_full[sel_dest]) begin
                            out_wr_q    <= 4'b0001 << sel_dest;
                            fwd_count_q <= fwd_count_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        err_q    <= 1'b1;
                        active_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_PUSH: begin
                    // A set out_wr_q marks the push cycle itself; otherwise we are stalled.
                    if (out_wr_q != '0) begin
                        active_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (!out_full[dest_q]) begin
                        out_wr_q    <= 4'b0001 << dest_q;
                        fwd_count_q <= fwd_count_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_rd     = in_rd_q;
    assign out_wr    = out_wr_q;
    assign out_data  = hold_q;
    assign active    = active_q;
    assign err       = err_q;
    assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: vector table, corner-case sequences and a randomized run
// checked against a transaction-level model of grant order and routing.
`timescale 1ns/1ps
module tb_fifo_rr_scheduler;

    localparam int unsigned DW = 6;
    localparam int unsigned CW = 8;
`ifdef SCHED_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic            clk;
    logic            RESET_L;
    logic [3:0]      in_empty;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_valid;
    logic [3:0]      in_rd;
    logic [3:0]      out_almost_full;
    logic [3:0]      out_full;
    logic [3:0]      out_wr;
    logic [DW-1:0]   out_data;
    logic            active;
    logic            err;
    logic [CW-1:0]   fwd_count;

    fifo_rr_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .RESET_L         (RESET_L),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_rd           (in_rd),
        .out_almost_full (out_almost_full),
        .out_full        (out_full),
        .out_wr          (out_wr),
        .out_data        (out_data),
        .active          (active),
        .err             (err),
        .fwd_count       (fwd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [DW-1:0] q [4][$];
    logic [DW-1:0] expq [$];
    logic [3:0]    pend_rd;
    logic [3:0]    s_empty, s_af, s_full;
    bit            drop_valid, mon_en, busy;
    int            mptr, mcount;

    typedef struct {
        int            src;
        logic [DW-1:0] word;
        logic [3:0]    af;
        logic [3:0]    exp_rd;
        logic [3:0]    exp_wr;
        logic [DW-1:0] exp_data;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Model: grant = first non-empty from pointer when idle and no almost-full;
    // each popped word must reach output dest in order, never into a full FIFO.
    task automatic monitor();
        int            idx;
        int            d;
        logic [3:0]    exp_rd;
        logic [DW-1:0] w;
        if (in_rd != '0) begin
            idx = -1;
            for (int k = 0; k < 4; k++) begin
                if (idx < 0 && !s_empty[(mptr + k) % 4]) idx = (mptr + k) % 4;
            end
            exp_rd = (idx >= 0 && s_af == '0 && !busy) ? 4'(1 << idx) : 4'b0;
            check("mon_grant", 32'(in_rd), 32'(exp_rd));
            if (idx >= 0 && !STRICT) mptr = (idx + 1) % 4;
            busy = 1'b1;
        end
        if (out_wr != '0) begin
            if (expq.size() == 0) begin
                check("mon_push_unexpected", 32'(out_wr), 32'd0);
            end else begin
                w = expq.pop_front();
                d = int'(w[DW-1 -: 2]);
                check("mon_push_port", 32'(out_wr), s_full[d] ? 32'd0 : 32'(1 << d));
                check("mon_push_data", 32'(out_data), 32'(w));
                mcount = (mcount + 1) % (1 << CW);
                check("mon_count", 32'(fwd_count), 32'(mcount));
            end
            busy = 1'b0;
        end
    endtask

    // One clock: input FIFOs answer last cycle's pop with valid data.
    task automatic step();
        logic [DW-1:0] w;
        for (int i = 0; i < 4; i++) in_empty[i] = (q[i].size() == 0);
        s_empty = in_empty;
        s_af    = out_almost_full;
        s_full  = out_full;
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en) monitor();
        in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            if (pend_rd[i] && q[i].size() > 0) begin
                w = q[i].pop_front();
                if (mon_en) expq.push_back(w);
                if (!drop_valid) begin
                    in_valid[i] = 1'b1;
                    in_data[i*DW +: DW] = w;
                end
            end
        end
        pend_rd = in_rd;
        for (int i = 0; i < 4; i++) in_empty[i] = (q[i].size() == 0);
    endtask

    task automatic do_reset();
        RESET_L = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        expq.delete();
        pend_rd = '0; in_valid = '0; in_data = '0; in_empty = '1;
        out_full = '0; out_almost_full = '0;
        drop_valid = 1'b0; mon_en = 1'b0; busy = 1'b0; mptr = 0; mcount = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", 32'({in_rd, out_wr}), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_flags", 32'({active, err}), 32'd0);
        check("rst_count", 32'(fwd_count), 32'd0);
        RESET_L = 1'b1;
    endtask

    task automatic wait_rd(output logic [3:0] rd);
        rd = '0;
        for (int k = 0; k < 16 && rd == '0; k++) begin
            step();
            rd = in_rd;
        end
    endtask

    task automatic test_rr();
        int gi[$];
        int gt[$];
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) for (int k = 0; k < 5; k++) q[i].push_back(DW'($urandom));
        for (int k = 0; k < 40 && gi.size() < 5; k++) begin
            step();
            if (in_rd != '0) begin
                gi.push_back(oh2idx(in_rd));
                gt.push_back(cyc);
            end
        end
        check("rr_grants", 32'(gi.size()), 32'd5);
        for (int k = 0; k < gi.size(); k++) begin
            check("rr_order", 32'(gi[k]), STRICT ? 32'd0 : 32'(k % 4));
            if (k > 0) check("rr_spacing", 32'(gt[k] - gt[k-1]), 32'd4);
        end
        repeat (2) step();
        check("rr_push5", 32'(out_wr != '0), 32'd1);
        check("rr_count5", 32'(fwd_count), 32'd5);
    endtask

    task automatic test_table();
        logic [3:0] rd;
        bit         seen;
        vecs[0] = '{2, 6'b100101, 4'b0000, 4'b0100, 4'b0100, 6'b100101};
        vecs[1] = '{0, 6'b110011, 4'b0000, 4'b0001, 4'b1000, 6'b110011};
        vecs[2] = '{3, 6'b000000, 4'b0000, 4'b1000, 4'b0001, 6'b000000};
        vecs[3] = '{1, 6'b011110, 4'b0000, 4'b0010, 4'b0010, 6'b011110};
        vecs[4] = '{0, 6'b111111, 4'b0001, 4'b0001, 4'b1000, 6'b111111};
        vecs[5] = '{3, 6'b101010, 4'b1000, 4'b1000, 4'b0100, 6'b101010};
        do_reset();
        mon_en = 1'b1;
        for (int v = 0; v < 6; v++) begin
            out_almost_full = vecs[v].af;
            q[vecs[v].src].push_back(vecs[v].word);
            if (vecs[v].af != '0) begin
                seen = 1'b0;
                repeat (10) begin
                    step();
                    if (in_rd != '0) seen = 1'b1;
                end
                check("tbl_af_hold", 32'(seen), 32'd0);
                out_almost_full = '0;
                step();
                rd = in_rd;
            end else begin
                wait_rd(rd);
            end
            check("tbl_rd", 32'(rd), 32'(vecs[v].exp_rd));
            repeat (2) step();
            check("tbl_wr", 32'(out_wr), 32'(vecs[v].exp_wr));
            check("tbl_data", 32'(out_data), 32'(vecs[v].exp_data));
            step();
        end
    endtask

    task automatic test_stall();
        logic [3:0] rd;
        do_reset();
        mon_en = 1'b1;
        q[1].push_back(6'b110001);
        out_full = 4'b1000;
        wait_rd(rd);
        check("stall_rd", 32'(rd), 32'b0010);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_wr", 32'(out_wr), 32'd0);
            check("stall_active", 32'(active), 32'd1);
        end
        out_full = '0;
        step();
        check("stall_push", 32'(out_wr), 32'b1000);
        check("stall_data", 32'(out_data), 32'b110001);
        check("stall_count", 32'(fwd_count), 32'd1);
        step();
        check("stall_done", 32'({active, out_wr}), 32'd0);
    endtask

    task automatic test_err();
        logic [3:0] rd;
        do_reset();
        drop_valid = 1'b1;
        q[0].push_back(6'b010101);
        wait_rd(rd);
        check("err_rd", 32'(rd), 32'b0001);
        step();
        step();
        check("err_set", 32'(err), 32'd1);
        check("err_idle", 32'(active), 32'd0);
        check("err_nopush", 32'(out_wr), 32'd0);
        drop_valid = 1'b0;
        q[2].push_back(6'b000111);
        wait_rd(rd);
        check("err_next_rd", 32'(rd), 32'b0100);
        repeat (2) step();
        check("err_next_push", 32'(out_wr), 32'b0001);
        check("err_next_count", 32'(fwd_count), 32'd1);
        repeat (5) step();
        check("err_sticky", 32'(err), 32'd1);
        do_reset();
    endtask

    task automatic test_async();
        logic [3:0] rd;
        do_reset();
        q[0].push_back(6'b011001);
        wait_rd(rd);
        repeat (3) step();
        q[2].push_back(6'b110110);
        wait_rd(rd);
        check("async_rd", 32'(rd), 32'b0100);
        step();
        check("async_in_wait", 32'({active, fwd_count}), 32'({1'b1, 8'd1}));
        #2 RESET_L = 1'b0;
        #1;
        check("async_strobes", 32'({in_rd, out_wr}), 32'd0);
        check("async_flags", 32'({active, err}), 32'd0);
        check("async_data", 32'(out_data), 32'd0);
        check("async_count", 32'(fwd_count), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("async_nopush", 32'({out_wr, active}), 32'd0);
        do_reset();
    endtask

    task automatic test_two();
        int gi[$];
        do_reset();
        mon_en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (q[1].size() < 2) q[1].push_back(DW'($urandom));
            if (q[3].size() < 2) q[3].push_back(DW'($urandom));
            step();
            if (in_rd != '0) gi.push_back(oh2idx(in_rd));
        end
        check("two_grants", 32'(gi.size() >= 10), 32'd1);
        for (int k = 0; k < gi.size(); k++) begin
            check("two_order", 32'(gi[k]), (STRICT || k % 2 == 0) ? 32'd1 : 32'd3);
        end
    endtask

    task automatic test_random();
        bit done;
        int i;
        do_reset();
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                i = int'($urandom_range(0, 3));
                if (q[i].size() < 6) q[i].push_back(DW'($urandom));
            end
            for (int j = 0; j < 4; j++) out_full[j] = ($urandom_range(0, 4) == 0);
            for (int j = 0; j < 4; j++) out_almost_full[j] = ($urandom_range(0, 19) == 0);
            step();
        end
        out_full = '0;
        out_almost_full = '0;
        done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            step();
            done = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) &&
                   (q[3].size() == 0) && (expq.size() == 0) && !busy && !active;
        end
        check("rand_drain", 32'(done), 32'd1);
        check("rand_err", 32'(err), 32'd0);
        check("rand_count", 32'(fwd_count), 32'(mcount));
    endtask

    initial begin
        RESET_L = 1'b0;
        in_empty = '1; in_valid = '0; in_data = '0;
        out_full = '0; out_almost_full = '0; pend_rd = '0;
        mon_en = 1'b0; drop_valid = 1'b0; busy = 1'b0; mptr = 0; mcount = 0;
        test_rr();
        test_table();
        test_stall();
        test_err();
        test_async();
        test_two();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
